ctrl_mem_datos: RTL and testbench

- Load/store initiator that drives the data-memory port on behalf of the CPU datapath.
- Accepts one byte, halfword or word access per request through a busy/done handshake.
- Issues active-low read and write strobes to the data memory and performs read-modify-write for sub-word stores.
- Returns aligned, sign- or zero-extended load data and sits between the execute stage and the data memory.

---
 rtl/ctrl_mem_datos.sv | 193 +++++++++++++++++++
 tb/tb_ctrl_mem_datos.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_mem_datos.sv
// ctrl_mem_datos: load/store initiator between the execute stage and the data memory.
// It accepts one byte, halfword or word access per request through a busy/done handshake.
// It drives active-low read and write strobes, and a sub-word store is done as a
// read-modify-write. Load data is returned aligned and sign- or zero-extended.
//
// Optional feature macro: LSU_SUBWORD_EN
//   defined   : byte and halfword loads and stores are supported (lane extract/extend, merge).
//   undefined : only word accesses are legal; byte/halfword complete as errors.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   req           : request, sampled only while idle (busy=0)
//   wr_en         : 1 = store, 0 = load
//   size          : 00 byte, 01 halfword, 10 word, 11 reserved
//   signed_ld     : sign-extend sub-word loads
//   addr, wdata   : byte address, right-justified store data
//   rdata         : load result, held until the next completed load
//   busy/done/err : handshake; err is valid with done
//   Mem_rd/Mem_wr : active-low memory strobes
//   Dir_Mem       : word address to memory (IDLE_DIR when no access)
//   Dato_Mem_in   : write data to memory
//   Dato_Mem_out  : read data from memory, valid the cycle after a sampled Mem_rd=0
module ctrl_mem_datos #(
    parameter logic [31:0] IDLE_DIR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr_en,
    input  logic [1:0]  size,
    input  logic        signed_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        Mem_rd,
    output logic        Mem_wr,
    output logic [31:0] Dir_Mem,
    output logic [31:0] Dato_Mem_in,
    input  logic [31:0] Dato_Mem_out
);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;
    state_t state;

`ifdef LSU_SUBWORD_EN
    // Request fields needed after acceptance (only the sub-word path uses them).
    logic        wr_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    function automatic logic access_ok(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   access_ok = 1'b1;
            2'b01:   access_ok = ~off[0];
            2'b10:   access_ok = (off == 2'b00);
            default: access_ok = 1'b0;
        endcase
    endfunction

    // Little-endian lane extraction followed by sign/zero extension.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   load_extend = {{24{sgn & b[7]}}, b};
            2'b01:   load_extend = {{16{sgn & h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Replace the addressed lane of the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wd,
                                                input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] m;
        m = word;
        if (sz == 2'b00)
            m[{off, 3'b000} +: 8] = wd[7:0];
        else if (off[1])
            m[31:16] = wd;
        else
            m[15:0] = wd;
        store_merge = m;
    endfunction
`else
    // Without sub-word support the sign-extension control has no effect.
    logic unused_sigs;
    assign unused_sigs = signed_ld;

    function automatic logic access_ok(input logic [1:0] sz, input logic [1:0] off);
        access_ok = (sz == 2'b10) && (off == 2'b00);
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            Mem_rd      <= 1'b1;
            Mem_wr      <= 1'b1;
            Dir_Mem     <= IDLE_DIR;
            Dato_Mem_in <= 32'h0;
            rdata       <= 32'h0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef LSU_SUBWORD_EN
            wr_q        <= 1'b0;
            size_q      <= 2'b00;
            sgn_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= 16'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
`ifdef LSU_SUBWORD_EN
                        wr_q    <= wr_en;
                        size_q  <= size;
                        sgn_q   <= signed_ld;
                        off_q   <= addr[1:0];
                        wdata_q <= wdata[15:0];
`endif
                        if (!access_ok(size, addr[1:0])) begin
                            // Illegal access completes immediately, no strobe issued.
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= DONE;
                        end else if (wr_en && size == 2'b10) begin
                            Mem_wr      <= 1'b0;
                            Dir_Mem     <= {addr[31:2], 2'b00};
                            Dato_Mem_in <= wdata;
                            state       <= WR;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            Mem_rd  <= 1'b0;
                            Dir_Mem <= {addr[31:2], 2'b00};
                            state   <= RD;
                        end
                    end
                end
                RD: begin
                    Mem_rd <= 1'b1;
                    state  <= RD_WAIT;
                end
                RD_WAIT: begin
`ifdef LSU_SUBWORD_EN
                    if (wr_q) begin
                        // Dir_Mem keeps the word address for the write-back.
                        Mem_wr      <= 1'b0;
                        Dato_Mem_in <= store_merge(Dato_Mem_out, wdata_q, size_q, off_q);
                        state       <= WR;
                    end else begin
                        rdata   <= load_extend(Dato_Mem_out, size_q, off_q, sgn_q);
                        done    <= 1'b1;
                        Dir_Mem <= IDLE_DIR;
                        state   <= DONE;
                    end
`else
                    rdata   <= Dato_Mem_out;
                    done    <= 1'b1;
                    Dir_Mem <= IDLE_DIR;
                    state   <= DONE;
`endif
                end
                WR: begin
                    Mem_wr  <= 1'b1;
                    done    <= 1'b1;
                    Dir_Mem <= IDLE_DIR;
                    state   <= DONE;
                end
                DONE: begin
                    // Any req seen here is ignored; acceptance resumes in IDLE.
                    done    <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    Dir_Mem <= IDLE_DIR;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_mem_datos.sv
// Self-checking bench for ctrl_mem_datos: directed scenarios followed by randomized
// accesses compared against a word-array reference model of memory and load results.
module tb_ctrl_mem_datos;

    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam logic [31:0] IDLE_DIR = 32'h0000_0000;
`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        signed_ld = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        busy, done, err, Mem_rd, Mem_wr;
    logic [31:0] Dir_Mem, Dato_Mem_in;
    logic [31:0] Dato_Mem_out = 32'h0;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic [31:0] ref_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    ctrl_mem_datos #(.IDLE_DIR(IDLE_DIR)) dut (
        .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .size(size),
        .signed_ld(signed_ld), .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .err(err), .Mem_rd(Mem_rd), .Mem_wr(Mem_wr),
        .Dir_Mem(Dir_Mem), .Dato_Mem_in(Dato_Mem_in), .Dato_Mem_out(Dato_Mem_out)
    );

    always #5 clk = ~clk;

    // Data memory: read data valid only in the cycle after a sampled Mem_rd=0.
    always @(posedge clk) begin
        if (!Mem_rd) Dato_Mem_out <= mem[Dir_Mem[5:2]];
        else         Dato_Mem_out <= $urandom;
        if (!Mem_wr) mem[Dir_Mem[5:2]] <= Dato_Mem_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0:    return !SUBWORD;
            2'd1:    return !SUBWORD || (a % 2 != 0);
            2'd2:    return (a % 4 != 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input bit sgn, input logic [31:0] a);
        logic [31:0] s;
        s = w >> (8 * (a % 4));
        if (sz == 2'd0) begin
            s = s & 32'hFF;
            if (sgn && s >= 128) s = s + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            s = s & 32'hFFFF;
            if (sgn && s >= 32768) s = s + 32'hFFFF_0000;
        end else begin
            s = w;
        end
        return s;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask, lane;
        if (sz == 2'd0) begin
            mask = 32'hFF << (8 * (a % 4));
            lane = (wd & 32'hFF) << (8 * (a % 4));
        end else if (sz == 2'd1) begin
            mask = 32'hFFFF << (8 * (a % 4));
            lane = (wd & 32'hFFFF) << (8 * (a % 4));
        end else begin
            return wd;
        end
        return (w & ~mask) | lane;
    endfunction

    // One full transaction: drive, observe every cycle until done, check, and
    // check the first idle cycle afterwards. Leaves req high when hold=1.
    task automatic do_access(input bit wr, input logic [1:0] sz, input bit sgn,
                             input logic [31:0] a, input logic [31:0] wd, input bit hold);
        int idx, n, rdc, wrc, both, notbusy, exp_lat, exp_rd, exp_wr;
        logic [31:0] rda, wra, wrd, expw;
        bit e, got;
        idx = int'(a[5:2]);
        e = model_err(sz, a);
        if (e)                 begin exp_lat = 1; exp_rd = 0; exp_wr = 0; end
        else if (!wr)          begin exp_lat = 3; exp_rd = 1; exp_wr = 0; end
        else if (sz == 2'd2)   begin exp_lat = 2; exp_rd = 0; exp_wr = 1; end
        else                   begin exp_lat = 4; exp_rd = 1; exp_wr = 1; end
        expw = model_store(ref_mem[idx], sz, a, wd);
        n = 0; rdc = 0; wrc = 0; both = 0; notbusy = 0; got = 0;
        rda = 32'h0; wra = 32'h0; wrd = 32'h0;

        @(negedge clk);
        req = 1'b1; wr_en = wr; size = sz; signed_ld = sgn; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        if (!hold) begin
            // Scramble the request fields so unlatched use would be visible.
            req = 1'b0; wr_en = 1'($urandom); size = 2'($urandom);
            signed_ld = 1'($urandom); addr = $urandom; wdata = $urandom;
        end
        for (int c = 1; c <= 12; c++) begin
            if (!Mem_rd && !Mem_wr) both++;
            if (!Mem_rd) begin rdc++; rda = Dir_Mem; end
            if (!Mem_wr) begin wrc++; wra = Dir_Mem; wrd = Dato_Mem_in; end
            if (!busy) notbusy++;
            if (done) begin got = 1; n = c; break; end
            @(posedge clk);
            #1;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", n, exp_lat);
        chk("err", 32'(err), 32'(e));
        chk("rd_strobes", rdc, exp_rd);
        chk("wr_strobes", wrc, exp_wr);
        chk("both_low", both, 0);
        chk("busy_low_during", notbusy, 0);
        if (exp_rd != 0) chk("rd_addr", rda, {a[31:2], 2'b00});
        if (exp_wr != 0) begin
            chk("wr_addr", wra, {a[31:2], 2'b00});
            chk("wr_data", wrd, expw);
            ref_mem[idx] = expw;
        end
        if (!e && !wr) ref_rdata = model_load(ref_mem[idx], sz, sgn, a);
        chk("rdata", rdata, ref_rdata);

        @(posedge clk);
        #1;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_strobes", {30'd0, Mem_rd, Mem_wr}, 32'd3);
        chk("idle_dir", Dir_Mem, IDLE_DIR);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int idx, c2;
        bit swr;
        logic [1:0] ssz;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1] = 32'h0BE1_2120;
        ref_mem[1] = 32'h0BE1_2120;

        // Reset values
        #1 rst = 1'b1;
        #20;
        chk("rst_Mem_rd", 32'(Mem_rd), 32'd1);
        chk("rst_Mem_wr", 32'(Mem_wr), 32'd1);
        chk("rst_Dir_Mem", Dir_Mem, IDLE_DIR);
        chk("rst_Dato_Mem_in", Dato_Mem_in, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed scenarios
        do_access(1'b0, 2'd0, 1'b1, 32'h1000_0006, 32'h0, 1'b0);
        chk("tp_sbyte", rdata, SUBWORD ? 32'hFFFF_FFE1 : 32'h0);
        do_access(1'b0, 2'd1, 1'b0, 32'h1000_0006, 32'h0, 1'b0);
        chk("tp_uhalf", rdata, SUBWORD ? 32'h0000_0BE1 : 32'h0);
        do_access(1'b1, 2'd0, 1'b0, 32'h1000_0005, 32'h0000_0055, 1'b0);
        do_access(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, 1'b0);
        chk("tp_word_after_bstore", rdata, SUBWORD ? 32'h0BE1_5520 : 32'h0BE1_2120);
        do_access(1'b0, 2'd2, 1'b0, 32'h1000_0002, 32'h0, 1'b0);
        chk("tp_misaligned_keep", rdata, SUBWORD ? 32'h0BE1_5520 : 32'h0BE1_2120);

        // Word store with req held high: second acceptance only on first IDLE cycle
        do_access(1'b1, 2'd2, 1'b0, 32'h1000_0008, 32'h1234_5678, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_wr", 32'(Mem_wr), 32'd0);
        req = 1'b0;
        c2 = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) break;
            c2++;
            @(posedge clk);
            #1;
        end
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_latency", c2, 1);
        @(posedge clk);
        #1;
        do_access(1'b0, 2'd2, 1'b0, 32'h1000_0008, 32'h0, 1'b0);
        chk("b2b_readback", rdata, 32'h1234_5678);

        // Reset in RD_WAIT: sub-word store when supported, otherwise a word load
        swr = SUBWORD;
        ssz = SUBWORD ? 2'd0 : 2'd2;
        idx = 3;
        @(negedge clk);
        req = 1'b1; wr_en = swr; size = ssz; signed_ld = 1'b0;
        addr = SUBWORD ? 32'h1000_000D : 32'h1000_000C; wdata = 32'h0000_00AA;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mrst_Mem_rd", 32'(Mem_rd), 32'd1);
        chk("mrst_Mem_wr", 32'(Mem_wr), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_rdata", rdata, 32'h0);
        ref_rdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        c2 = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (!Mem_wr || !Mem_rd || busy) c2++;
        end
        chk("mrst_no_activity", c2, 0);
        chk("mrst_mem_kept", mem[idx], ref_mem[idx]);

        // Randomized accesses
        for (int t = 0; t < 250; t++) begin
            do_access(1'($urandom), 2'($urandom), 1'($urandom),
                      BASE + $urandom_range(0, 63), $urandom, 1'b0);
        end

        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
